// File: rtl/color_mixer_stream.sv
// Streaming four-operand colour mixer: per channel computes (A*B) op (C*D),
// then rounds, saturates and bit-expands the result back to the interface width.
// Three registered stages share one advance enable so a stalled output freezes
// the whole pipe and s_ready tells the source when a beat can be taken.
module color_mixer_stream #(
  parameter int NUMBER_OF_SUB_PIXEL      = 4,
  parameter int SUB_PIXEL_WIDTH          = 8,
  parameter int SUB_PIXEL_CALC_PRECISION = SUB_PIXEL_WIDTH,
  parameter int USER_WIDTH               = 1,
  localparam int PIXEL_WIDTH             = SUB_PIXEL_WIDTH * NUMBER_OF_SUB_PIXEL
) (
  input  logic                   aclk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [1:0]             s_op,
  input  logic [PIXEL_WIDTH-1:0] s_colorA,
  input  logic [PIXEL_WIDTH-1:0] s_colorB,
  input  logic [PIXEL_WIDTH-1:0] s_colorC,
  input  logic [PIXEL_WIDTH-1:0] s_colorD,
  input  logic [USER_WIDTH-1:0]  s_user,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [PIXEL_WIDTH-1:0] m_color,
  output logic [USER_WIDTH-1:0]  m_user
);

  localparam int N   = NUMBER_OF_SUB_PIXEL;
  localparam int SPW = SUB_PIXEL_WIDTH;
  localparam int P   = SUB_PIXEL_CALC_PRECISION;
  localparam int SW  = 2 * P + 2;

  localparam logic [SW-1:0] M_EXT = SW'((2 ** P) - 1);
  localparam logic [P-1:0]  M_P   = '1;
  localparam logic [P-1:0]  HALF  = P'(2 ** (P - 1));

  typedef enum logic [1:0] {
    OP_ADD        = 2'd0,
    OP_SUB        = 2'd1,
    OP_ADD_SIGNED = 2'd2,
    OP_MODULATE   = 2'd3
  } op_e;

  logic                       adv;

  logic                       valid1_q, valid1_d;
  op_e                        op1_q, op1_d;
  logic [USER_WIDTH-1:0]      user1_q, user1_d;
  logic [N-1:0][2*P-1:0]      x_q, x_d;
  logic [N-1:0][2*P-1:0]      y_q, y_d;

  logic                       valid2_q, valid2_d;
  op_e                        op2_q, op2_d;
  logic [USER_WIDTH-1:0]      user2_q, user2_d;
  logic [N-1:0][SW-1:0]       s_q, s_d;

  logic                       m_valid_q, m_valid_d;
  logic [USER_WIDTH-1:0]      m_user_q, m_user_d;
  logic [PIXEL_WIDTH-1:0]     m_color_q, m_color_d;

  // Round a non-negative two's complement sum back to P bits, saturate,
  // apply the signed bias for ADD_SIGNED, then replicate bits to widen.
  function automatic logic [SPW-1:0] finish_channel(input logic [SW-1:0] s, input op_e op);
    logic [SW-1:0] rounded;
    logic [P-1:0]  r;
    rounded = '0;
    r       = '0;
    if (!s[SW-1]) begin
      rounded = (s + M_EXT) >> P;
      if (rounded > M_EXT) r = M_P;
      else                 r = rounded[P-1:0];
    end
    if (op == OP_ADD_SIGNED) begin
      if (r < HALF) r = '0;
      else          r = r - HALF;
    end
    return SPW'({r, r} >> (2 * P - SPW));
  endfunction

  assign adv     = !m_valid_q || m_ready;
  assign s_ready = adv;
  assign m_valid = m_valid_q;
  assign m_color = m_color_q;
  assign m_user  = m_user_q;

  // Stage 1: extract the top P bits of each operand channel and form both products.
  always_comb begin
    valid1_d = valid1_q;
    op1_d    = op1_q;
    user1_d  = user1_q;
    x_d      = x_q;
    y_d      = y_q;
    if (adv) begin
      valid1_d = s_valid;
      op1_d    = op_e'(s_op);
      user1_d  = s_user;
      for (int i = 0; i < N; i++) begin
        x_d[i] = (2*P)'(s_colorA[i*SPW + SPW-P +: P]) * (2*P)'(s_colorB[i*SPW + SPW-P +: P]);
        y_d[i] = (2*P)'(s_colorC[i*SPW + SPW-P +: P]) * (2*P)'(s_colorD[i*SPW + SPW-P +: P]);
      end
    end
  end

  // Stage 2: combine the products into a signed sum wide enough for X+Y and X-Y.
  always_comb begin
    valid2_d = valid2_q;
    op2_d    = op2_q;
    user2_d  = user2_q;
    s_d      = s_q;
    if (adv) begin
      valid2_d = valid1_q;
      op2_d    = op1_q;
      user2_d  = user1_q;
      for (int i = 0; i < N; i++) begin
        case (op1_q)
          OP_SUB:      s_d[i] = {2'b00, x_q[i]} - {2'b00, y_q[i]};
          OP_MODULATE: s_d[i] = {2'b00, x_q[i]};
          default:     s_d[i] = {2'b00, x_q[i]} + {2'b00, y_q[i]};
        endcase
      end
    end
  end

  // Stage 3: normalise into the output register; bubbles leave the data untouched.
  always_comb begin
    m_valid_d = m_valid_q;
    m_user_d  = m_user_q;
    m_color_d = m_color_q;
    if (adv) begin
      m_valid_d = valid2_q;
      if (valid2_q) begin
        m_user_d = user2_q;
        for (int i = 0; i < N; i++) begin
          m_color_d[i*SPW +: SPW] = finish_channel(s_q[i], op2_q);
        end
      end
    end
  end

  // All pipeline registers; reset flushes every in-flight beat and zeroes the output.
  always_ff @(posedge aclk) begin
    if (reset) begin
      valid1_q  <= 1'b0;
      op1_q     <= OP_ADD;
      user1_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      valid2_q  <= 1'b0;
      op2_q     <= OP_ADD;
      user2_q   <= '0;
      s_q       <= '0;
      m_valid_q <= 1'b0;
      m_user_q  <= '0;
      m_color_q <= '0;
    end else begin
      valid1_q  <= valid1_d;
      op1_q     <= op1_d;
      user1_q   <= user1_d;
      x_q       <= x_d;
      y_q       <= y_d;
      valid2_q  <= valid2_d;
      op2_q     <= op2_d;
      user2_q   <= user2_d;
      s_q       <= s_d;
      m_valid_q <= m_valid_d;
      m_user_q  <= m_user_d;
      m_color_q <= m_color_d;
    end
  end

endmodule
